// File: rtl/croc_pkg.sv
// Shared definitions for the GPIO input conditioning path.
package croc_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } gpio_filt_state_e;

  localparam int GpioSyncStages     = 2;
  localparam int GpioDebounceCycles = 4;

endpackage

// File: rtl/gpio_filter_pin.sv
// One GPIO pin: synchronizer, stable-count debounce FSM, edge detect and sticky pending bit.
module gpio_filter_pin
  import croc_pkg::*;
#(
  parameter int SyncStages     = GpioSyncStages,
  parameter int DebounceCycles = GpioDebounceCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  input  logic debounce_en,
  input  logic rise_en,
  input  logic fall_en,
  input  logic clear,
  output logic sync,
  output logic filt,
  output logic pending
);

  localparam int CntWidth = $clog2(DebounceCycles + 1);
  // Count value on which the next differing sample completes the stable run.
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  gpio_filt_state_e      state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  filt_q, filt_d;
  logic                  pending_q, pending_d;
  logic                  edge_set;

  assign sync = sync_q[SyncStages-1];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;

    unique case (state_q)
      STABLE: begin
        if (sync != filt_q) begin
          if (DebounceCycles == 1) begin
            filt_d = sync;
          end else begin
            state_d = CHANGING;
            cnt_d   = CntWidth'(1);
          end
        end
      end
      CHANGING: begin
        if (sync == filt_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          filt_d  = sync;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase

    // Bypass: follow the synchronized level and abandon any count in progress.
    if (!debounce_en) begin
      filt_d  = sync;
      state_d = STABLE;
      cnt_d   = '0;
    end

    edge_set  = (filt_d & ~filt_q & rise_en) | (~filt_d & filt_q & fall_en);
    // A set on the same edge as a clear wins so no event is dropped.
    pending_d = edge_set | (pending_q & ~clear);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= STABLE;
      cnt_q     <= '0;
      filt_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q    <= {sync_q[SyncStages-2:0], pad};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      pending_q <= pending_d;
    end
  end

  assign filt    = filt_q;
  assign pending = pending_q;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-pin synchronize, debounce, edge capture; one combined interrupt.
module gpio_in_filter
  import croc_pkg::*;
#(
  parameter int GpioCount      = 16,
  parameter int SyncStages     = GpioSyncStages,
  parameter int DebounceCycles = GpioDebounceCycles
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [GpioCount-1:0] gpio_i,
  input  logic [GpioCount-1:0] debounce_en_i,
  input  logic [GpioCount-1:0] rise_irq_en_i,
  input  logic [GpioCount-1:0] fall_irq_en_i,
  input  logic [GpioCount-1:0] irq_clear_i,
  output logic [GpioCount-1:0] gpio_sync_o,
  output logic [GpioCount-1:0] gpio_filt_o,
  output logic [GpioCount-1:0] irq_pending_o,
  output logic                 irq_o
);

  for (genvar i = 0; i < GpioCount; i++) begin : g_pin
    gpio_filter_pin #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles)
    ) u_pin (
      .clk        (clk_i),
      .rst        (rst_i),
      .pad        (gpio_i[i]),
      .debounce_en(debounce_en_i[i]),
      .rise_en    (rise_irq_en_i[i]),
      .fall_en    (fall_irq_en_i[i]),
      .clear      (irq_clear_i[i]),
      .sync       (gpio_sync_o[i]),
      .filt       (gpio_filt_o[i]),
      .pending    (irq_pending_o[i])
    );
  end

  assign irq_o = |irq_pending_o;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Scoreboard bench for gpio_in_filter: drivers queue timed expectations, a monitor retires them.
module tb_gpio_in_filter;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] gpio = '0, deb_en = '0, rise_en = '0, fall_en = '0, clr = '0;
  logic [N-1:0] sync_o, filt_o, pend_o;
  logic         irq;

  gpio_in_filter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .gpio_i       (gpio),
    .debounce_en_i(deb_en),
    .rise_irq_en_i(rise_en),
    .fall_irq_en_i(fall_en),
    .irq_clear_i  (clr),
    .gpio_sync_o  (sync_o),
    .gpio_filt_o  (filt_o),
    .irq_pending_o(pend_o),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  typedef enum {F_SYNC, F_FILT, F_PEND, F_IRQ} field_e;
  typedef struct {
    string        name;
    int           cycle;
    bit           now;
    field_e       field;
    logic [N-1:0] mask;
    logic [N-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  event chk_ev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] actual(field_e f);
    case (f)
      F_SYNC:  return sync_o;
      F_FILT:  return filt_o;
      F_PEND:  return pend_o;
      default: return {{(N-1){1'b0}}, irq};
    endcase
  endfunction

  task automatic check(exp_t e);
    logic [N-1:0] a;
    a = actual(e.field);
    n_checks++;
    if ((a & e.mask) !== (e.val & e.mask)) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (mask %h) at cycle %0d",
               e.name, a & e.mask, e.val & e.mask, e.mask, cyc);
    end
  endtask

  // Expectation checked at the falling edge after n more rising edges.
  task automatic push_exp(string name, int n, field_e f, logic [N-1:0] mask, logic [N-1:0] val);
    exp_t e;
    e.name = name; e.cycle = cyc + n; e.now = 1'b0; e.field = f; e.mask = mask; e.val = val;
    sb.push_back(e);
  endtask

  // Expectation checked immediately when chk_ev fires (used between clock edges).
  task automatic push_now(string name, field_e f, logic [N-1:0] mask, logic [N-1:0] val);
    exp_t e;
    e.name = name; e.cycle = -1; e.now = 1'b1; e.field = f; e.mask = mask; e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_all_zero(string name);
    push_now({name, "_sync"}, F_SYNC, '1, '0);
    push_now({name, "_filt"}, F_FILT, '1, '0);
    push_now({name, "_pend"}, F_PEND, '1, '0);
    push_now({name, "_irq"},  F_IRQ,  '1, '0);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk or chk_ev);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].now || sb[i].cycle == cyc) begin
          check(sb[i]);
          sb.delete(i);
        end
      end
    end
  end

  localparam logic [N-1:0] P3 = 16'h0008;
  localparam logic [N-1:0] P7 = 16'h0080;

  initial begin
    // Reset state, then idle pads for 20 cycles.
    step(3);
    #2;
    push_all_zero("in_reset");
    -> chk_ev;
    step(1);
    rst = 1'b0;
    push_exp("idle_sync", 20, F_SYNC, '1, '0);
    push_exp("idle_filt", 20, F_FILT, '1, '0);
    push_exp("idle_pend", 20, F_PEND, '1, '0);
    push_exp("idle_irq",  20, F_IRQ,  '1, '0);
    step(21);

    // Clean rising edge on pin 3.
    deb_en = '1;
    rise_en = P3;
    gpio[3] = 1'b1;
    push_exp("rise3_sync_e1", 1, F_SYNC, P3, '0);
    push_exp("rise3_sync_e2", 2, F_SYNC, P3, P3);
    push_exp("rise3_filt_e5", 5, F_FILT, P3, '0);
    push_exp("rise3_pend_e5", 5, F_PEND, P3, '0);
    push_exp("rise3_filt_e6", 6, F_FILT, P3, P3);
    push_exp("rise3_pend_e6", 6, F_PEND, P3, P3);
    push_exp("rise3_irq_e6",  6, F_IRQ,  '1, 16'h0001);
    step(8);

    // Fall with fall capture disabled: pending remains from the rise.
    gpio[3] = 1'b0;
    push_exp("fall3_filt_e5", 5, F_FILT, P3, P3);
    push_exp("fall3_filt_e6", 6, F_FILT, P3, '0);
    push_exp("fall3_pend_kept", 6, F_PEND, P3, P3);
    step(8);
    clr[3] = 1'b1;
    push_exp("clr3_pend", 1, F_PEND, P3, '0);
    push_exp("clr3_irq",  1, F_IRQ,  '1, '0);
    step(1);
    clr[3] = 1'b0;

    // Three-cycle glitch is rejected.
    gpio[3] = 1'b1;
    push_exp("glitch_sync_hi", 2, F_SYNC, P3, P3);
    push_exp("glitch_filt_e6", 6, F_FILT, P3, '0);
    push_exp("glitch_filt_e9", 9, F_FILT, P3, '0);
    push_exp("glitch_pend_e9", 9, F_PEND, P3, '0);
    step(3);
    gpio[3] = 1'b0;
    push_exp("glitch_sync_lo", 2, F_SYNC, P3, '0);
    step(8);

    // Eight-cycle pulse: rise and fall both accepted after the filter latency.
    fall_en[3] = 1'b1;
    gpio[3] = 1'b1;
    push_exp("pulse_rise_filt_e5", 5, F_FILT, P3, '0);
    push_exp("pulse_rise_filt_e6", 6, F_FILT, P3, P3);
    push_exp("pulse_rise_pend_e6", 6, F_PEND, P3, P3);
    step(8);
    gpio[3] = 1'b0;
    push_exp("pulse_fall_filt_e5", 5, F_FILT, P3, P3);
    push_exp("pulse_fall_filt_e6", 6, F_FILT, P3, '0);
    push_exp("pulse_fall_pend_e6", 6, F_PEND, P3, P3);
    step(8);
    clr[3] = 1'b1;
    push_exp("pulse_clr_pend", 1, F_PEND, P3, '0);
    step(1);
    clr[3] = 1'b0;
    step(1);

    // Pin 7 unfiltered: filt follows sync one edge later.
    deb_en[7] = 1'b0;
    fall_en[7] = 1'b1;
    gpio[7] = 1'b1;
    push_exp("byp7_rise_filt_e2", 2, F_FILT, P7, '0);
    push_exp("byp7_rise_filt_e3", 3, F_FILT, P7, P7);
    push_exp("byp7_rise_nopend",  3, F_PEND, P7, '0);
    step(4);
    gpio[7] = 1'b0;
    push_exp("byp7_fall_filt_e2", 2, F_FILT, P7, P7);
    push_exp("byp7_fall_pend_e2", 2, F_PEND, P7, '0);
    push_exp("byp7_fall_filt_e3", 3, F_FILT, P7, '0);
    push_exp("byp7_fall_pend_e3", 3, F_PEND, P7, P7);
    push_exp("byp7_fall_irq_e3",  3, F_IRQ,  '1, 16'h0001);
    step(4);
    clr[7] = 1'b1;
    push_exp("byp7_clr_pend", 1, F_PEND, P7, '0);
    push_exp("byp7_clr_irq",  1, F_IRQ,  '1, '0);
    step(1);
    clr[7] = 1'b0;
    step(1);

    // Clear coinciding with an accepted rise: the set wins.
    rise_en[3] = 1'b1;
    gpio[3] = 1'b1;
    push_exp("setclr_pend_e5", 5, F_PEND, P3, '0);
    push_exp("setclr_filt_e6", 6, F_FILT, P3, P3);
    push_exp("setclr_pend_e6", 6, F_PEND, P3, P3);
    step(5);
    clr[3] = 1'b1;
    step(1);
    clr[3] = 1'b0;
    rise_en[3] = 1'b0;
    push_exp("en_off_keeps_pend", 1, F_PEND, P3, P3);
    step(1);
    clr[3] = 1'b1;
    push_exp("clr_alone_pend", 1, F_PEND, P3, '0);
    push_exp("clr_alone_irq",  1, F_IRQ,  '1, '0);
    step(1);
    clr[3] = 1'b0;
    step(1);

    // All pins toggled with capture disabled.
    deb_en = '1;
    rise_en = '0;
    fall_en = '0;
    gpio = 16'hFFFF;
    push_exp("all_hi_filt_e5", 5, F_FILT, '1, P3);
    push_exp("all_hi_filt_e6", 6, F_FILT, '1, 16'hFFFF);
    push_exp("all_hi_pend",    6, F_PEND, '1, '0);
    push_exp("all_hi_irq",     6, F_IRQ,  '1, '0);
    step(8);
    gpio = 16'hA5A5;
    push_exp("a5_filt_e5", 5, F_FILT, '1, 16'hFFFF);
    push_exp("a5_filt_e6", 6, F_FILT, '1, 16'hA5A5);
    push_exp("a5_pend",    6, F_PEND, '1, '0);
    step(8);

    // Rising edges on the low pins, then an asynchronous reset between edges.
    rise_en = '1;
    gpio = 16'hFFFF;
    push_exp("mix_filt_e5", 5, F_FILT, '1, 16'hA5A5);
    push_exp("mix_pend_e5", 5, F_PEND, '1, '0);
    push_exp("mix_filt_e6", 6, F_FILT, '1, 16'hFFFF);
    push_exp("mix_pend_e6", 6, F_PEND, '1, 16'h5A5A);
    push_exp("mix_irq_e6",  6, F_IRQ,  '1, 16'h0001);
    step(8);
    #2;
    rst = 1'b1;
    #1;
    push_all_zero("async_rst");
    -> chk_ev;
    #1;
    step(2);
    rst = 1'b0;
    // Pad held high through reset produces a rise once the filter fills.
    push_exp("post_rst_sync_e2", 2, F_SYNC, '1, 16'hFFFF);
    push_exp("post_rst_filt_e5", 5, F_FILT, '1, '0);
    push_exp("post_rst_pend_e5", 5, F_PEND, '1, '0);
    push_exp("post_rst_filt_e6", 6, F_FILT, '1, 16'hFFFF);
    push_exp("post_rst_pend_e6", 6, F_PEND, '1, 16'hFFFF);
    step(8);

    foreach (sb[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked, expected %h at cycle %0d", sb[i].name, sb[i].val, sb[i].cycle);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
- Input conditioning stage between the GPIO input pads and the consumers of the synchronized GPIO input vector (croc and user domains).
- Per pin, it synchronizes the raw pad level, debounces it with a stable-count filter, and detects rising and falling edges on the filtered level.
- It latches edge events into sticky pending bits and raises one combined interrupt toward the external interrupt vector.
- It replaces the bare input synchronizer on the pad path.

Parameters:
- GpioCount, 16: number of GPIO pins handled.
- SyncStages, 2: flip-flop stages in the per-pin synchronizer. Must be >=2.
- DebounceCycles, 4: consecutive stable synchronized samples required to accept a new level. Must be >=1.
- CntWidth, $clog2(DebounceCycles+1): width of the per-pin stable counter. Derived, not overridable.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: reset.
- gpio_i, input, GpioCount: raw pad input levels, asynchronous to clk_i.
- debounce_en_i, input, GpioCount: 1 = filter the pin; 0 = filtered output follows the synchronized level.
- rise_irq_en_i, input, GpioCount: enables rising-edge capture per pin.
- fall_irq_en_i, input, GpioCount: enables falling-edge capture per pin.
- irq_clear_i, input, GpioCount: single-cycle clear pulse per pending bit.
- gpio_sync_o, output, GpioCount: synchronized, unfiltered level.
- gpio_filt_o, output, GpioCount: debounced level.
- irq_pending_o, output, GpioCount: sticky per-pin edge-pending bits.
- irq_o, output, 1: OR of irq_pending_o.

Behaviour:
- One clock, clk_i; rst_i is asynchronous, active-high.
- While rst_i is high, all of the following are 0:
  - synchronizer flops and gpio_sync_o
  - counters
  - gpio_filt_o
  - irq_pending_o and irq_o
  - per-pin FSM state, which sits in STABLE.
- Synchronizer: gpio_sync_o reflects a gpio_i change SyncStages rising edges after the change.
- Per-pin FSM has two states, STABLE and CHANGING, plus a counter cnt:
  - STABLE: if sync != filt, go to CHANGING and set cnt=1. Exception: when DebounceCycles==1, filt updates on this same edge and the FSM stays in STABLE.
  - CHANGING, sync == filt: return to STABLE, cnt=0 (glitch rejected).
  - CHANGING, sync != filt, cnt+1 == DebounceCycles: filt <= sync, go to STABLE, cnt=0.
  - CHANGING, otherwise: cnt <= cnt+1.
- Filter latency: a clean level change appears on gpio_filt_o SyncStages+DebounceCycles edges after the gpio_i change.
- Any sync reversal before acceptance restarts the count from zero. A pulse shorter than DebounceCycles synchronized cycles never reaches gpio_filt_o.
- debounce_en_i[i]==0: filt[i] <= sync[i] every edge, FSM forced to STABLE, cnt=0.
- debounce_en_i[i] toggling 1->0 mid-count aborts the count. Toggling 0->1 starts from the current filt.
- Edge detect: on the edge where filt[i] changes, set pending[i] if the corresponding enable is high:
  - 0->1 requires rise_irq_en_i[i].
  - 1->0 requires fall_irq_en_i[i].
- Clear: irq_clear_i[i] clears pending[i] on the next edge.
- Simultaneous set and clear on the same edge: set wins, so no event is lost.
- An enable deasserted while pending is set does not clear the pending bit.
- irq_o is combinational OR of the pending register bits (no extra latency).
- Edges occurring during reset are not captured. gpio_filt_o leaves reset at 0, so a pad held high produces a rising edge after reset release plus the filter latency.

Decomposition:
- Shared package (croc_pkg):
  - gpio_filt_state_e enum {STABLE, CHANGING}.
  - Default constants GpioSyncStages=2 and GpioDebounceCycles=4.
- Sub-module gpio_filter_pin: synchronizer, FSM, counter, filtered level and pending bit for one pin.
- Top level generates GpioCount instances and the irq_o reduction.

Test Plan:
- Reset, then gpio_i=16'h0000 held for 20 cycles -> gpio_sync_o, gpio_filt_o, irq_pending_o = 0, irq_o=0. Assert rst_i asynchronously mid-run -> all outputs 0 with no clock edge.
- debounce_en_i=all 1, rise_irq_en_i[3]=1, gpio_i[3] 0->1 -> gpio_sync_o[3]=1 after 2 edges; gpio_filt_o[3]=1 and irq_pending_o[3]=1 after 6 edges; irq_o=1.
- gpio_i[3] high for 3 synchronized cycles then low (glitch) -> gpio_filt_o[3] stays 0, no pending. Repeat with an 8-cycle pulse -> rise accepted at edge 6, fall accepted 6 edges after the fall.
- debounce_en_i[7]=0, fall_irq_en_i[7]=1, filt[7]=1, gpio_i[7] 1->0 -> gpio_filt_o[7]=0 after 3 edges, pending[7] set on that edge.
- irq_clear_i[3] pulsed on the same edge a new rising edge on pin 3 is accepted -> irq_pending_o[3] stays 1. Clear alone next cycle -> 0, irq_o=0.
- rise_irq_en_i=0, fall_irq_en_i=0, toggle all 16 pins -> gpio_filt_o tracks after 6 edges, irq_pending_o stays 16'h0000.
